// File: rtl/sdcard_loader_pkg.sv
// Shared types and constants for the SD-card block stream loader.
package sdcard_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_READBLOCK,
        S_BYTE_WAIT,
        S_BYTE_ACK,
        S_WRITE,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam logic [15:0] ERR_SD_TRUNC    = 16'hFF01;
    localparam logic [15:0] ERR_RAM_TIMEOUT = 16'hFF02;
    localparam int          SD_BLOCK_BYTES  = 512;

    // SDSC cards take a byte address, SDHC cards a block address.
    function automatic logic [31:0] sd_block_addr(input logic [31:0] blk, input bit sdhc);
        return sdhc ? blk : (blk << $clog2(SD_BLOCK_BYTES));
    endfunction

endpackage

// File: rtl/sd_word_packer.sv
// Assembles successive SD bytes into one RAM word; tracks the byte lane index.
module sd_word_packer #(
    parameter int WORD_BYTES = 8,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_capture,
    input  logic [7:0]              i_byte,
    input  logic                    i_advance,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic [IDX_W-1:0]        o_byte_idx,
    output logic                    o_word_full
);

    logic [IDX_W-1:0]        r_idx;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [IDX_W-1:0]        w_lane;

    assign w_lane      = MSB_FIRST ? (IDX_W'(WORD_BYTES - 1) - r_idx) : r_idx;
    assign o_word_full = (r_idx == IDX_W'(WORD_BYTES - 1));
    assign o_word      = r_word;
    assign o_byte_idx  = r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else begin
            if (i_capture)
                r_word[{w_lane, 3'b000} +: 8] <= i_byte;
            if (i_clr)
                r_idx <= '0;
            else if (i_advance)
                r_idx <= o_word_full ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/sdcard_stream_loader.sv
// Streams raw SD blocks from a runtime start block into consecutive RAM words.
module sdcard_stream_loader
    import sdcard_loader_pkg::*;
#(
    parameter int WORD_BYTES  = 8,
    parameter int ADDR_W      = 23,
    parameter bit MSB_FIRST   = 1'b0,
    parameter bit SDHC        = 1'b1,
    parameter int RAM_TIMEOUT = 1024
) (
    input  logic                    clk50,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [31:0]             base_block,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         num_words,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [8*WORD_BYTES-1:0] ram_data,
    input  logic                    ram_op_begun,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             err_code,
    output logic [ADDR_W:0]         words_written,
    output logic                    sd_rd,
    output logic                    sd_continue,
    output logic [31:0]             sd_addr,
    input  logic [7:0]              sd_data,
    input  logic                    sd_busy,
    input  logic                    sd_hndshk_o,
    output logic                    sd_hndshk_i,
    input  logic [15:0]             sd_error
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMO_W = $clog2(RAM_TIMEOUT + 1);

    loader_state_t     r_state;
    logic [31:0]       r_base_block;
    logic [31:0]       r_blk_idx;
    logic [ADDR_W:0]   r_num_words;
    logic [ADDR_W:0]   r_words_written;
    logic [ADDR_W-1:0] r_ram_address;
    logic [TMO_W-1:0]  r_tmo;
    logic [15:0]       r_err_code;
    logic [31:0]       r_sd_addr;
    logic              r_ram_we, r_busy, r_done, r_error;
    logic              r_sd_rd, r_sd_continue, r_sd_hndshk_i;

    logic              w_start, w_capture, w_advance, w_word_full;
    logic [IDX_W-1:0]  w_byte_idx;
    logic [ADDR_W:0]   w_ww_next;

    assign w_start   = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_capture = (r_state == S_BYTE_WAIT) && sd_hndshk_o;
    assign w_advance = (r_state == S_BYTE_ACK) && !sd_hndshk_o;
    assign w_ww_next = r_words_written + (ADDR_W + 1)'(1);

    sd_word_packer #(
        .WORD_BYTES (WORD_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_packer (
        .clk         (clk50),
        .rst_n       (reset_n),
        .i_clr       (w_start),
        .i_capture   (w_capture),
        .i_byte      (sd_data),
        .i_advance   (w_advance),
        .o_word      (ram_data),
        .o_byte_idx  (w_byte_idx),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_base_block    <= '0;
            r_blk_idx       <= '0;
            r_num_words     <= '0;
            r_words_written <= '0;
            r_ram_address   <= '0;
            r_tmo           <= '0;
            r_err_code      <= '0;
            r_sd_addr       <= '0;
            r_ram_we        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_sd_rd         <= 1'b0;
            r_sd_continue   <= 1'b0;
            r_sd_hndshk_i   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_base_block    <= base_block;
                        r_num_words     <= num_words;
                        r_ram_address   <= base_addr;
                        r_blk_idx       <= '0;
                        r_words_written <= '0;
                        r_err_code      <= '0;
                        r_done          <= 1'b0;
                        r_error         <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (!sd_busy) begin
                        if (sd_error != '0) begin
                            r_err_code <= sd_error;
                            r_error    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_ERROR;
                        end else if (r_num_words == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_sd_rd       <= 1'b1;
                            r_sd_continue <= 1'b0;
                            r_sd_addr     <= sd_block_addr(r_base_block, SDHC);
                            r_state       <= S_READBLOCK;
                        end
                    end
                end
                S_READBLOCK: begin
                    if (sd_busy) begin
                        r_sd_rd       <= 1'b0;
                        r_sd_continue <= 1'b0;
                        r_state       <= S_BYTE_WAIT;
                    end
                end
                S_BYTE_WAIT: begin
                    if (sd_hndshk_o) begin
                        r_sd_hndshk_i <= 1'b1;
                        r_state       <= S_BYTE_ACK;
                    end else if (!sd_busy) begin
                        // A block always holds a whole number of words, so the
                        // controller may only go idle on a word boundary.
                        if (w_byte_idx == '0) begin
                            r_blk_idx     <= r_blk_idx + 32'd1;
                            r_sd_rd       <= 1'b1;
                            r_sd_continue <= 1'b1;
                            r_sd_addr     <= sd_block_addr(r_base_block + r_blk_idx + 32'd1, SDHC);
                            r_state       <= S_READBLOCK;
                        end else begin
                            r_err_code <= ERR_SD_TRUNC;
                            r_error    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_ERROR;
                        end
                    end
                end
                S_BYTE_ACK: begin
                    if (!sd_hndshk_o) begin
                        r_sd_hndshk_i <= 1'b0;
                        if (w_word_full) begin
                            r_ram_we <= 1'b1;
                            r_tmo    <= '0;
                            r_state  <= S_WRITE;
                        end else begin
                            r_state <= S_BYTE_WAIT;
                        end
                    end
                end
                S_WRITE: begin
                    // The acknowledge wins over a timeout landing on the same cycle.
                    if (ram_op_begun) begin
                        r_ram_we        <= 1'b0;
                        r_ram_address   <= r_ram_address + ADDR_W'(1);
                        r_words_written <= w_ww_next;
                        r_state         <= (w_ww_next == r_num_words) ? S_DRAIN : S_BYTE_WAIT;
                    end else if (r_tmo == TMO_W'(RAM_TIMEOUT - 1)) begin
                        r_ram_we   <= 1'b0;
                        r_err_code <= ERR_RAM_TIMEOUT;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_sd_hndshk_i) begin
                        if (!sd_hndshk_o)
                            r_sd_hndshk_i <= 1'b0;
                    end else if (sd_hndshk_o) begin
                        r_sd_hndshk_i <= 1'b1;
                    end else if (!sd_busy) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_we        = r_ram_we;
    assign ram_address   = r_ram_address;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign words_written = r_words_written;
    assign sd_rd         = r_sd_rd;
    assign sd_continue   = r_sd_continue;
    assign sd_addr       = r_sd_addr;
    assign sd_hndshk_i   = r_sd_hndshk_i;

endmodule
